misc_tickcap: RTL and testbench

Parametrised tick-capture unit for the misc peripheral space: counts `NCH` independent single-cycle tick inputs (E1 RX/TX recovered clocks, per-port framers, …) and, on each capture strobe (USB SOF), pushes a snapshot of all channel counters plus a free-running timestamp into a `DEPTH`-entry FIFO. Firmware drains snapshots over Wishbone, so no SOF interval is lost while the USB stack is busy. It is the multi-channel, buffered successor of the single-register E1 tick capture.

---
 rtl/misc_tickcap_if.sv | 29 ++
 rtl/misc_tickcap.sv | 192 +++++++++++++++++++
 tb/tb_misc_tickcap.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/misc_tickcap_if.sv
// Wishbone-style register bus for misc_tickcap.
// The master drives the address, data, write enable and cycle request; the slave returns the
// registered read data and the acknowledge.
interface misc_tickcap_if;
  logic [3:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr,
    output wb_wdata,
    output wb_we,
    output wb_cyc,
    input  wb_rdata,
    input  wb_ack
  );

  modport slave (
    input  wb_addr,
    input  wb_wdata,
    input  wb_we,
    input  wb_cyc,
    output wb_rdata,
    output wb_ack
  );
endinterface

// File: rtl/misc_tickcap.sv
// misc_tickcap: multi-channel tick counter with a buffered snapshot FIFO.
// Each cap strobe pushes {timestamp, cnt[0..NCH-1] + tick} into a DEPTH-entry FIFO that firmware
// drains over the register bus (status, head timestamp, head snapshots, pop).
// Build option: define TICKCAP_DELTA_EN for delta mode (counters reload to 0 on every cap and
// saturate instead of wrapping). Without it the counters free-run and wrap.
module misc_tickcap #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned W     = 16,
  parameter int unsigned TW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] tick,
  input  logic           cap,
  misc_tickcap_if.slave  wb
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [W-1:0]    CntMax  = '1;

  localparam logic [3:0] AddrStatus = 4'h0;
  localparam logic [3:0] AddrTs     = 4'h1;
  localparam logic [3:0] AddrPop    = 4'hF;

  // Channel counters and timestamp
  logic [W-1:0]  cnt_q    [NCH];
  logic [W-1:0]  cnt_d    [NCH];
  logic [W-1:0]  snap_val [NCH];
  logic [TW-1:0] ts_q;

  // FIFO storage and bookkeeping
  logic [TW-1:0]   ts_mem   [DEPTH];
  logic [W-1:0]    snap_mem [DEPTH][NCH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            fifo_empty, fifo_full;

  // Bus side
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;
  logic        wr_commit;
  logic        pop_en, flush, ovf_clr;
  logic        push_en, drop;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlFull);

  // Write side effects take effect only in the ack cycle, so each write commits exactly once.
  assign wr_commit = ack_q & wb.wb_cyc & wb.wb_we;
  assign pop_en    = wr_commit & (wb.wb_addr == AddrPop) & ~fifo_empty;
  assign flush     = wr_commit & (wb.wb_addr == AddrStatus) & wb.wb_wdata[1];
  assign ovf_clr   = wr_commit & (wb.wb_addr == AddrStatus) & wb.wb_wdata[0];

  // A simultaneous pop frees the slot, so a cap at full still lands; flush discards the cap.
  assign push_en = cap & ~flush & (~fifo_full | pop_en);
  assign drop    = cap & ~flush & fifo_full & ~pop_en;

  // Snapshot value includes a tick coincident with cap; next counter value depends on the mode.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
`ifdef TICKCAP_DELTA_EN
      snap_val[k] = (tick[k] && (cnt_q[k] != CntMax)) ? cnt_q[k] + W'(1) : cnt_q[k];
      cnt_d[k]    = cap ? '0 : snap_val[k];
`else
      snap_val[k] = cnt_q[k] + W'(tick[k]);
      cnt_d[k]    = snap_val[k];
`endif
    end
  end

  // Channel counters and free-running timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
      ts_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      ts_q <= ts_q + TW'(1);
    end
  end

  // FIFO pointer, level and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push_en && !pop_en) begin
        level_d = level_q + LvlW'(1);
      end else if (pop_en && !push_en) begin
        level_d = level_q - LvlW'(1);
      end
    end
    // Set has priority so an overflow in the clearing cycle is not lost.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage: no reset, contents are only visible through a valid level
  always_ff @(posedge clk) begin
    if (push_en) begin
      ts_mem[wr_ptr_q] <= ts_q;
      for (int k = 0; k < NCH; k++) begin
        snap_mem[wr_ptr_q][k] <= snap_val[k];
      end
    end
  end

  // Register read mux; head registers read as 0 while the FIFO is empty
  always_comb begin
    rd_mux = '0;
    if (wb.wb_addr == AddrStatus) begin
      rd_mux = {21'd0, ovf_q, fifo_full, fifo_empty, 8'(level_q)};
    end else if (wb.wb_addr == AddrTs) begin
      if (!fifo_empty) begin
        rd_mux = 32'(ts_mem[rd_ptr_q]);
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if ((wb.wb_addr == 4'(k + 2)) && !fifo_empty) begin
          rd_mux = 32'(snap_mem[rd_ptr_q][k]);
        end
      end
    end
  end

  // Two-cycle access: ack rises one cycle after cyc and drops the next; rdata valid with ack
  always_comb begin
    ack_d   = wb.wb_cyc & ~ack_q;
    rdata_d = (wb.wb_cyc && !ack_q) ? rd_mux : '0;
  end

  // Bus response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdata = rdata_q;

  // Only the command bits of the write data are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^wb.wb_wdata[31:2];

endmodule

// File: tb/tb_misc_tickcap.sv
// Self-checking bench for misc_tickcap (NCH=2, W=4, TW=32, DEPTH=4).
// A reference model keeps a scoreboard queue of expected snapshots, pushed on cap and popped on
// committed pop writes; register reads are compared against it and against fixed constants.
module tb_misc_tickcap;

  localparam int unsigned NCH   = 2;
  localparam int unsigned W     = 4;
  localparam int unsigned TW    = 32;
  localparam int unsigned DEPTH = 4;

`ifdef TICKCAP_DELTA_EN
  localparam bit Delta = 1'b1;
`else
  localparam bit Delta = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] tick;
  logic           cap;

  misc_tickcap_if bus ();

  misc_tickcap #(
    .NCH  (NCH),
    .W    (W),
    .TW   (TW),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .cap  (cap),
    .wb   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0]  ts;
    logic [W-1:0] s [NCH];
  } ent_t;

  ent_t         sb [$];
  logic [W-1:0] m_cnt [NCH];
  logic [31:0]  m_ts;
  logic         m_ack;
  logic         m_ovf;
  logic         m_commit, m_pop_req, m_flush, m_clr;

  assign m_commit  = m_ack && bus.wb_cyc && bus.wb_we;
  assign m_pop_req = m_commit && (bus.wb_addr == 4'hF);
  assign m_flush   = m_commit && (bus.wb_addr == 4'h0) && bus.wb_wdata[1];
  assign m_clr     = m_commit && (bus.wb_addr == 4'h0) && bus.wb_wdata[0];

  function automatic logic [W-1:0] cnt_next(input logic [W-1:0] c, input logic t);
    if (Delta) return (t && (c != {W{1'b1}})) ? c + W'(1) : c;
    return c + W'(t);
  endfunction

  function automatic ent_t cap_entry();
    ent_t e;
    e.ts = m_ts;
    for (int k = 0; k < NCH; k++) e.s[k] = cnt_next(m_cnt[k], tick[k]);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ts  <= '0;
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
      for (int k = 0; k < NCH; k++) m_cnt[k] <= '0;
      sb.delete();
    end else begin
      if (m_pop_req && sb.size() != 0) void'(sb.pop_front());
      if (m_clr) m_ovf <= 1'b0;
      if (m_flush) sb.delete();
      else if (cap) begin
        if (sb.size() < DEPTH) sb.push_back(cap_entry());
        else m_ovf <= 1'b1;
      end
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] <= (Delta && cap) ? '0 : cnt_next(m_cnt[k], tick[k]);
      end
      m_ts  <= m_ts + 32'd1;
      m_ack <= bus.wb_cyc && !m_ack;
    end
  end

  function automatic logic [31:0] exp_status();
    int n = sb.size();
    return {21'd0, m_ovf, n == DEPTH, n == 0, 8'(n)};
  endfunction

  function automatic logic [31:0] exp_ts();
    if (sb.size() == 0) return '0;
    return sb[0].ts;
  endfunction

  function automatic logic [31:0] exp_snap(input int k);
    if (sb.size() == 0) return '0;
    return 32'(sb[0].s[k]);
  endfunction

  // ---------------- stimulus helpers ----------------
  // n cycles of tick pattern t; cap raised in the last of them when c is set
  task automatic pulses(input int n, input logic [NCH-1:0] t, input logic c);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = t;
      cap  = c && (i == n - 1);
    end
    @(negedge clk);
    tick = '0;
    cap  = 1'b0;
  endtask

  // One bus access; c raises cap in the ack (commit) cycle
  task automatic wb_xfer(input logic [3:0] a, input logic w, input logic [31:0] wd,
                         input logic c, output logic [31:0] rd);
    @(negedge clk);
    bus.wb_addr  = a;
    bus.wb_we    = w;
    bus.wb_wdata = wd;
    bus.wb_cyc   = 1'b1;
    @(negedge clk);
    chk("ack_rise", bus.wb_ack, 32'd1);
    rd  = bus.wb_rdata;
    cap = c;
    @(negedge clk);
    chk("ack_single", bus.wb_ack, 32'd0);
    chk("rdata_after_ack", bus.wb_rdata, 32'd0);
    cap        = 1'b0;
    bus.wb_cyc = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    wb_xfer(a, 1'b0, 32'd0, 1'b0, d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic c);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, wd, c, dummy);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d, a_snap, b_snap, prev_ts;

  initial begin
    rst_n        = 1'b0;
    tick         = '0;
    cap          = 1'b0;
    bus.wb_cyc   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", bus.wb_ack, 32'd0);
    chk("reset_rdata", bus.wb_rdata, 32'd0);
    rst_n = 1'b1;
    rd(4'h0, d); chk("reset_status", d, 32'h100);

    // 10 ticks on channel 0, cap on the 10th
    pulses(10, 2'b01, 1'b1);
    rd(4'h0, d); chk("t1_status", d, 32'h001);
    rd(4'h2, d); chk("t1_snap0", d, 32'd10);
    rd(4'h3, d); chk("t1_snap1", d, 32'd0);
    rd(4'h1, d); chk("t1_ts", d, exp_ts());
    pulses(1, 2'b00, 1'b1);
    wr(4'hF, 32'd0, 1'b0);
    rd(4'h2, d); chk("t1_second_snap0", d, Delta ? 32'd0 : 32'd10);
    wr(4'hF, 32'd0, 1'b0);
    rd(4'h0, d); chk("t1_drained", d, 32'h100);

    // 6 caps into a 4-deep FIFO
    for (int i = 0; i < 6; i++) pulses(1, 2'b00, 1'b1);
    rd(4'h0, d); chk("ovf_status", d, 32'h604);
    prev_ts = '0;
    for (int i = 0; i < 4; i++) begin
      rd(4'h1, d);
      chk("ovf_head_ts", d, exp_ts());
      if (i > 0) chk("ovf_ts_increasing", 32'(d > prev_ts), 32'd1);
      prev_ts = d;
      wr(4'hF, 32'd0, 1'b0);
    end
    rd(4'h0, d); chk("ovf_empty_status", d, 32'h500);
    rd(4'h1, d); chk("empty_head_ts", d, 32'd0);
    rd(4'h2, d); chk("empty_head_snap", d, 32'd0);
    wr(4'h0, 32'd1, 1'b0);
    rd(4'h0, d); chk("ovf_cleared", d, 32'h100);

    // Full FIFO, cap coincident with pop
    for (int i = 0; i < 4; i++) pulses(2 + i, 2'b10, 1'b1);
    rd(4'h0, d); chk("full_status", d, 32'h204);
    wr(4'hF, 32'd0, 1'b1);
    rd(4'h0, d); chk("full_cap_pop_status", d, 32'h204);
    for (int i = 0; i < 4; i++) begin
      rd(4'h1, d); chk("cap_pop_ts", d, exp_ts());
      rd(4'h3, d); chk("cap_pop_snap1", d, exp_snap(1));
      wr(4'hF, 32'd0, 1'b0);
    end
    rd(4'h0, d); chk("cap_pop_drained", d, exp_status());

    // 20 ticks between caps with W=4
    pulses(1, 2'b00, 1'b1);
    pulses(20, 2'b01, 1'b0);
    pulses(1, 2'b00, 1'b1);
    rd(4'h2, a_snap); chk("w4_first", a_snap, exp_snap(0));
    wr(4'hF, 32'd0, 1'b0);
    rd(4'h2, b_snap); chk("w4_second", b_snap, exp_snap(0));
    wr(4'hF, 32'd0, 1'b0);
`ifdef TICKCAP_DELTA_EN
    chk("w4_saturate", b_snap, 32'd15);
`else
    chk("w4_wrap_delta", (b_snap - a_snap) & 32'hF, 32'd4);
`endif

    // Clear coincident with overflow, then flush coincident with cap at level 2
    for (int i = 0; i < 4; i++) pulses(1, 2'b11, 1'b1);
    wr(4'h0, 32'd1, 1'b1);
    rd(4'h0, d); chk("clear_vs_overflow", d, 32'h604);
    wr(4'hF, 32'd0, 1'b0);
    wr(4'hF, 32'd0, 1'b0);
    rd(4'h0, d); chk("level2_status", d, 32'h402);
    wr(4'h0, 32'd2, 1'b1);
    rd(4'h0, d); chk("flush_cap_status", d, 32'h500);
    wr(4'h0, 32'd1, 1'b0);
    rd(4'h0, d); chk("ovf_write_clear", d, 32'h100);

    // Cap coincident with pop at level 0: push only
    wr(4'hF, 32'd0, 1'b1);
    rd(4'h0, d); chk("empty_cap_pop_status", d, 32'h001);
    rd(4'h1, d); chk("empty_cap_pop_ts", d, exp_ts());
    rd(4'h3, d); chk("empty_cap_pop_snap1", d, exp_snap(1));
    wr(4'h0, 32'd2, 1'b0);

    // Reset asserted mid-read with cyc high
    pulses(1, 2'b00, 1'b1);
    @(negedge clk);
    bus.wb_addr = 4'h0;
    bus.wb_we   = 1'b0;
    bus.wb_cyc  = 1'b1;
    @(negedge clk);
    chk("pre_reset_ack", bus.wb_ack, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ack", bus.wb_ack, 32'd0);
    chk("async_reset_rdata", bus.wb_rdata, 32'd0);
    chk("async_reset_level", 32'(dut.level_q), 32'd0);
    chk("async_reset_ts", dut.ts_q, 32'd0);
    bus.wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'h0, d); chk("post_reset_status", d, 32'h100);
    pulses(3, 2'b01, 1'b1);
    rd(4'h1, d); chk("post_reset_ts", d, exp_ts());
    rd(4'h2, d); chk("post_reset_snap0", d, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
